timer_countdown: RTL and testbench
==================================

# timer_countdown

Cooking-time entry and countdown stage of the microwave controller. It accepts BCD digits from the keypad into an MM:SS register, counts down once per second while the magnetron is on, and drives `timer_done` into the magnetron control stage, which drops `mag_on` when `timer_done` rises. Display logic reads the four digit outputs.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per countdown second; must be ≥ 2.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `clearn`  in  1  synchronous active-low clear, same pushbutton that feeds magnetron control.
- `key_valid`  in  1  one-cycle pulse: `key_code` holds a new digit.
- `key_code`  in  4  BCD digit 0–9; values 10–15 are ignored.
- `mag_on`  in  1  magnetron-on level from magnetron control; enables counting.
- `timer_done`  out  1  high whenever all four digits are zero.
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens`  out  4 each  BCD time digits.
- `running`  out  1  high in state RUN.

## Operation
- Digit register: four BCD nibbles, displayed as `min_tens min_ones : sec_tens sec_ones`.
- FSM states: EMPTY (all digits zero, not running), ARMED (nonzero, not running), RUN.
  - EMPTY/ARMED → RUN when `mag_on`=1 and digits nonzero.
  - RUN → ARMED when `mag_on` falls with digits nonzero (pause). Prescaler holds its value.
  - RUN → EMPTY when the digits reach zero, or when `clearn`=0.
  - ARMED → EMPTY on `clearn`=0.
- Key entry is accepted only outside RUN, with `mag_on`=0, `key_code` ≤ 9 and `min_tens` = 0.
  - Accepted key shifts left: `min_tens`←`min_ones`←`sec_tens`←`sec_ones`←`key_code`.
  - An accepted key clears the prescaler.
  - When `min_tens` ≠ 0 the register is full and further keys are ignored.
- Entry does not normalise: `sec_tens` may hold 6–9 (e.g. 00:99 counts 99, 98 … 90, 89 …).
- Prescaler: 0 … CLK_HZ−1, width $clog2(CLK_HZ). It increments while `mag_on`=1 and the digits are nonzero.
- Decrement: when the prescaler equals CLK_HZ−1, the prescaler wraps to 0 and the time decrements by one second.
- BCD borrow chain:
  - `sec_ones` 0→9 borrows from `sec_tens`.
  - `sec_tens` 0→5 borrows from `min_ones`.
  - `min_ones` 0→9 borrows from `min_tens`.
  - Decrement at zero never occurs.
- `clearn`=0 zeroes the digits and the prescaler and forces state EMPTY. Clear has priority over a key and over a decrement in the same cycle.

## Timing
- Reset (`resetn`=0, asynchronous):
  - all digits 0, prescaler 0, state EMPTY;
  - `timer_done`=1, `running`=0.
- `timer_done` is decoded combinationally from the registered digits: all-zero → 1.
  - It is high the same cycle the last decrement lands, so magnetron control drops `mag_on` one edge later.
  - `timer_done` is never high while the digits are nonzero.
- Key latency: the digit appears on the outputs the cycle after the `key_valid` edge.
- Countdown period: exactly CLK_HZ cycles of `mag_on`=1 per second. Pause time is excluded.
- First decrement comes CLK_HZ cycles after `mag_on` first rises from a fresh entry.
- `mag_on` high while EMPTY: no counting, no state change; `timer_done` stays 1.
- Reset asserted mid-RUN aborts immediately. No decrement occurs on release.

## Structure
- Package `microwave_pkg`:
  - FSM state enum (EMPTY, ARMED, RUN);
  - BCD constants: digit max 9, seconds-tens reload 5.
- Sub-module `bcd_digit_down`:
  - one nibble with `load`, `dec` and a `reload` value input;
  - outputs `is_zero` and `borrow`.
  - Instantiated four times in a borrow chain.
- Prescaler and FSM live in the top module.

## Test plan
- Reset: `resetn` pulsed low → digits 0000, `timer_done`=1, `running`=0.
- Key entry: keys 1,3,0 → 01:30, `timer_done`=0. Keys 5,7 → 13:05; a further key 9 → ignored, stays 13:05. Key 12 → ignored.
- Countdown: CLK_HZ=4, load 00:02, hold `mag_on`=1 → 00:01 after 4 cycles, 00:00 and `timer_done`=1 after 8 cycles, state EMPTY.
- Borrow: load 10:00, count one second → 09:59. Load 00:90, one second → 00:89.
- Pause/resume: CLK_HZ=4, load 00:05, `mag_on` high 2 cycles, low 10 cycles, high 2 cycles → decrement to 00:04 exactly at cumulative on-cycle 4. Keys pressed while `mag_on`=1 → ignored.
- Priority: `clearn`=0 coincident with `key_valid` and a decrement edge → 0000, EMPTY, `timer_done`=1. `mag_on`=1 in EMPTY → no change.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and BCD constants for the microwave controller timer stage.
package microwave_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } timer_state_t;

    localparam logic [3:0] BCD_MAX         = 4'd9;
    localparam logic [3:0] SEC_TENS_RELOAD = 4'd5;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD nibble of the countdown register: load, decrement, and reload on underflow.
module bcd_digit_down (
    input  logic       clock,
    input  logic       resetn,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    input  logic [3:0] reload,
    output logic [3:0] q,
    output logic       is_zero,
    output logic       borrow
);

    logic [3:0] r_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_q <= 4'd0;
        else if (clr)
            r_q <= 4'd0;
        else if (load)
            r_q <= load_val;
        else if (dec)
            r_q <= is_zero ? reload : r_q - 4'd1;
    end

    assign q       = r_q;
    assign is_zero = (r_q == 4'd0);
    // Wrapping this digit takes one from the next-higher digit.
    assign borrow  = dec & is_zero;

endmodule

// File: rtl/timer_countdown.sv
// MM:SS keypad entry and per-second countdown; flags timer_done when all digits reach zero.
module timer_countdown
    import microwave_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       mag_on,
    output logic       timer_done,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running
);

    localparam int              PW   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PMAX = PW'(CLK_HZ - 1);

    timer_state_t    r_state;
    logic            r_running;
    logic [PW-1:0]   r_presc;

    logic [3:0][3:0] w_dig;
    logic [3:0][3:0] w_ld_val;
    logic [3:0][3:0] w_reload;
    logic [3:0]      w_dec;
    logic [3:0]      w_zero;
    logic [3:0]      w_borrow;
    logic            w_nonzero;
    logic            w_last;
    logic            w_count;
    logic            w_tick;
    logic            w_key_ok;

    assign w_nonzero = ~&w_zero;
    assign w_last    = &w_zero[3:1] & (w_dig[0] == 4'd1);
    assign w_count   = mag_on & w_nonzero;
    assign w_tick    = w_count & (r_presc == PMAX);
    assign w_key_ok  = key_valid & ~mag_on & (r_state != ST_RUN)
                     & (key_code <= BCD_MAX) & w_zero[3];

    // Index 0 is sec_ones; a key shifts every digit one place toward min_tens.
    assign w_ld_val = {w_dig[2], w_dig[1], w_dig[0], key_code};
    assign w_dec    = {w_borrow[2:0], w_tick};
    assign w_reload = {BCD_MAX, BCD_MAX, SEC_TENS_RELOAD, BCD_MAX};

    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit_down u_dig (
            .clock    (clock),
            .resetn   (resetn),
            .clr      (~clearn),
            .load     (w_key_ok),
            .load_val (w_ld_val[i]),
            .dec      (w_dec[i]),
            .reload   (w_reload[i]),
            .q        (w_dig[i]),
            .is_zero  (w_zero[i]),
            .borrow   (w_borrow[i])
        );
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_presc <= '0;
        else if (!clearn || w_key_ok)
            r_presc <= '0;
        else if (w_count)
            r_presc <= (r_presc == PMAX) ? '0 : r_presc + 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_EMPTY;
            r_running <= 1'b0;
        end else if (!clearn) begin
            r_state   <= ST_EMPTY;
            r_running <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY, ST_ARMED: begin
                    if (w_count) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end else begin
                        r_state   <= w_nonzero ? ST_ARMED : ST_EMPTY;
                        r_running <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Leave RUN on the same edge the final decrement lands.
                    if ((w_tick && w_last) || !w_nonzero) begin
                        r_state   <= ST_EMPTY;
                        r_running <= 1'b0;
                    end else if (!mag_on) begin
                        r_state   <= ST_ARMED;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_EMPTY;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign sec_ones   = w_dig[0];
    assign sec_tens   = w_dig[1];
    assign min_ones   = w_dig[2];
    assign min_tens   = w_dig[3];
    assign timer_done = ~w_nonzero;
    assign running    = r_running;

endmodule

// File: tb/tb_timer_countdown.sv
// Directed checks of keypad entry, countdown, BCD borrow, pause and clear priority.
module tb_timer_countdown;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        clearn = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        mag_on = 1'b0;
    logic        timer_done;
    logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
    logic        running;
    logic [15:0] t;

    int checks = 0;
    int errors = 0;

    timer_countdown #(.CLK_HZ(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .clearn     (clearn),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .mag_on     (mag_on),
        .timer_done (timer_done),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running)
    );

    always #5 clock = ~clock;
    assign t = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        checks++; if (t !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", t); end
        checks++; if (timer_done !== 1'b1) begin errors++; $display("FAIL reset_done got %b want 1", timer_done); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
        step(1);
        resetn = 1'b1;
        step(1);
    endtask

    task automatic test_key_entry();
        clear_pulse();
        press(4'd12);
        checks++; if (t !== 16'h0000) begin errors++; $display("FAIL key12_empty got %h want 0000", t); end
        press(4'd1); press(4'd3); press(4'd0);
        checks++; if (t !== 16'h0130) begin errors++; $display("FAIL key_130 got %h want 0130", t); end
        checks++; if (timer_done !== 1'b0) begin errors++; $display("FAIL key_done got %b want 0", timer_done); end
        press(4'd5); press(4'd7);
        checks++; if (t !== 16'h1305) begin errors++; $display("FAIL key_1305 got %h want 1305", t); end
        press(4'd9);
        checks++; if (t !== 16'h1305) begin errors++; $display("FAIL key_full got %h want 1305", t); end
        press(4'd12);
        checks++; if (t !== 16'h1305) begin errors++; $display("FAIL key12_full got %h want 1305", t); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL key_running got %b want 0", running); end
    endtask

    task automatic test_countdown();
        clear_pulse();
        press(4'd0); press(4'd2);
        checks++; if (t !== 16'h0002) begin errors++; $display("FAIL cd_load got %h want 0002", t); end
        mag_on = 1'b1;
        step(3);
        checks++; if (t !== 16'h0002) begin errors++; $display("FAIL cd_3cyc got %h want 0002", t); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL cd_running got %b want 1", running); end
        step(1);
        checks++; if (t !== 16'h0001) begin errors++; $display("FAIL cd_4cyc got %h want 0001", t); end
        checks++; if (timer_done !== 1'b0) begin errors++; $display("FAIL cd_done_early got %b want 0", timer_done); end
        step(3);
        checks++; if (t !== 16'h0001) begin errors++; $display("FAIL cd_7cyc got %h want 0001", t); end
        step(1);
        checks++; if (t !== 16'h0000) begin errors++; $display("FAIL cd_8cyc got %h want 0000", t); end
        checks++; if (timer_done !== 1'b1) begin errors++; $display("FAIL cd_done got %b want 1", timer_done); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL cd_empty got %b want 0", running); end
        mag_on = 1'b0;
        step(1);
    endtask

    task automatic test_borrow();
        clear_pulse();
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        mag_on = 1'b1;
        step(4);
        mag_on = 1'b0;
        checks++; if (t !== 16'h0959) begin errors++; $display("FAIL borrow_1000 got %h want 0959", t); end
        step(1);
        clear_pulse();
        press(4'd9); press(4'd0);
        mag_on = 1'b1;
        step(4);
        mag_on = 1'b0;
        checks++; if (t !== 16'h0089) begin errors++; $display("FAIL borrow_0090 got %h want 0089", t); end
        step(1);
    endtask

    task automatic test_pause();
        clear_pulse();
        press(4'd5);
        mag_on = 1'b1;
        step(2);
        mag_on = 1'b0;
        step(10);
        checks++; if (t !== 16'h0005) begin errors++; $display("FAIL pause_hold got %h want 0005", t); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got %b want 0", running); end
        mag_on = 1'b1;
        step(1);
        checks++; if (t !== 16'h0005) begin errors++; $display("FAIL pause_on3 got %h want 0005", t); end
        step(1);
        checks++; if (t !== 16'h0004) begin errors++; $display("FAIL pause_on4 got %h want 0004", t); end
        press(4'd7);
        checks++; if (t !== 16'h0004) begin errors++; $display("FAIL key_while_on got %h want 0004", t); end
        mag_on = 1'b0;
        step(1);
    endtask

    task automatic test_priority();
        clear_pulse();
        press(4'd0); press(4'd1);
        mag_on = 1'b1;
        step(3);
        clearn    = 1'b0;
        key_valid = 1'b1;
        key_code  = 4'd5;
        step(1);
        clearn    = 1'b1;
        key_valid = 1'b0;
        checks++; if (t !== 16'h0000) begin errors++; $display("FAIL prio_digits got %h want 0000", t); end
        checks++; if (timer_done !== 1'b1) begin errors++; $display("FAIL prio_done got %b want 1", timer_done); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL prio_running got %b want 0", running); end
        step(6);
        checks++; if (t !== 16'h0000) begin errors++; $display("FAIL empty_mag_digits got %h want 0000", t); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL empty_mag_running got %b want 0", running); end
        checks++; if (timer_done !== 1'b1) begin errors++; $display("FAIL empty_mag_done got %b want 1", timer_done); end
        mag_on = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_run();
        clear_pulse();
        press(4'd0); press(4'd2);
        mag_on = 1'b1;
        step(3);
        resetn = 1'b0;
        #2;
        checks++; if (t !== 16'h0000) begin errors++; $display("FAIL rst_run_digits got %h want 0000", t); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_run_running got %b want 0", running); end
        step(1);
        resetn = 1'b1;
        step(3);
        checks++; if (t !== 16'h0000) begin errors++; $display("FAIL rst_release got %h want 0000", t); end
        mag_on = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_key_entry();
        test_countdown();
        test_borrow();
        test_pause();
        test_priority();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
